// File: rtl/sa_input_feeder.sv
// Input feeder for a 4x4 systolic array: buffers four A-column/B-row beats,
// then streams them diagonally skewed into the array and waits for completion.
module sa_input_feeder #(
   parameter int TIMEOUT = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [31:0] load_a,
   input  logic [31:0] load_b,
   output logic        sa_start,
   output logic        sa_in_valid,
   output logic [7:0]  a_in0,
   output logic [7:0]  a_in1,
   output logic [7:0]  a_in2,
   output logic [7:0]  a_in3,
   output logic [7:0]  b_in0,
   output logic [7:0]  b_in1,
   output logic [7:0]  b_in2,
   output logic [7:0]  b_in3,
   input  logic        sa_done,
   output logic        feed_done,
   output logic        feed_err
);

   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      LOAD      = 2'd0,
      STREAM    = 2'd1,
      WAIT_DONE = 2'd2,
      FINISH    = 2'd3
   } state_t;

   state_t        state_r, state_s;
   logic [1:0]    beat_cnt_r, beat_cnt_s;
   logic [3:0]    t_r, t_s;
   logic [WW-1:0] wait_r, wait_s;
   logic          accept_s;
   logic          err_s;

   logic [31:0]   a_buf_r [4];
   logic [31:0]   b_buf_r [4];
   logic [7:0]    a_r [4];
   logic [7:0]    b_r [4];
   logic [7:0]    a_s [4];
   logic [7:0]    b_s [4];

   logic          load_ready_r;
   logic          sa_start_r;
   logic          sa_in_valid_r;
   logic          feed_done_r;
   logic          feed_err_r;

   // State and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= LOAD;
         beat_cnt_r <= 2'd0;
         t_r        <= 4'd0;
         wait_r     <= '0;
      end else begin
         state_r    <= state_s;
         beat_cnt_r <= beat_cnt_s;
         t_r        <= t_s;
         wait_r     <= wait_s;
      end
   end

   // Next-state, counter and error-flag logic
   always_comb begin
      state_s    = state_r;
      beat_cnt_s = beat_cnt_r;
      t_s        = t_r;
      wait_s     = wait_r;
      err_s      = feed_err_r;
      accept_s   = 1'b0;
      case (state_r)
         LOAD: begin
            if (load_valid) begin
               accept_s   = 1'b1;
               beat_cnt_s = beat_cnt_r + 2'd1;
               if (beat_cnt_r == 2'd3) begin
                  state_s = STREAM;
                  t_s     = 4'd0;
               end else begin
                  state_s = LOAD;
               end
            end else begin
               state_s = LOAD;
            end
         end
         STREAM: begin
            if (t_r == 4'd9) begin
               state_s = WAIT_DONE;
               wait_s  = '0;
            end else begin
               t_s = t_r + 4'd1;
            end
         end
         WAIT_DONE: begin
            // sa_done wins over a coincident timeout
            if (sa_done) begin
               state_s = FINISH;
            end else if (wait_r == WW'(TIMEOUT - 1)) begin
               state_s = FINISH;
               err_s   = 1'b1;
            end else begin
               wait_s = wait_r + WW'(1);
            end
         end
         FINISH: begin
            state_s    = LOAD;
            beat_cnt_s = 2'd0;
            t_s        = 4'd0;
            wait_s     = '0;
         end
         default: begin
            state_s = LOAD;
         end
      endcase
   end

   // Beat buffers; written only while loading, so no reset is needed
   always_ff @(posedge clk) begin
      if (accept_s) begin
         a_buf_r[beat_cnt_r] <= load_a;
         b_buf_r[beat_cnt_r] <= load_b;
      end
   end

   // Skew selection for the cycle about to be presented: lane i shows beat t-i
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         a_s[i] = 8'd0;
         b_s[i] = 8'd0;
         if ((state_s == STREAM) && (t_s >= 4'(i)) && ((t_s - 4'(i)) <= 4'd3)) begin
            a_s[i] = a_buf_r[2'(t_s - 4'(i))][8*i +: 8];
            b_s[i] = b_buf_r[2'(t_s - 4'(i))][8*i +: 8];
         end else begin
            a_s[i] = 8'd0;
            b_s[i] = 8'd0;
         end
      end
   end

   // Registered array-facing and handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_ready_r  <= 1'b1;
         sa_start_r    <= 1'b0;
         sa_in_valid_r <= 1'b0;
         feed_done_r   <= 1'b0;
         feed_err_r    <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            a_r[i] <= 8'd0;
            b_r[i] <= 8'd0;
         end
      end else begin
         load_ready_r  <= (state_s == LOAD);
         sa_start_r    <= (state_s == STREAM) || (state_s == WAIT_DONE);
         sa_in_valid_r <= (state_s == STREAM) || (state_s == WAIT_DONE);
         feed_done_r   <= (state_s == FINISH);
         feed_err_r    <= err_s;
         for (int i = 0; i < 4; i++) begin
            a_r[i] <= a_s[i];
            b_r[i] <= b_s[i];
         end
      end
   end

   assign load_ready  = load_ready_r;
   assign sa_start    = sa_start_r;
   assign sa_in_valid = sa_in_valid_r;
   assign feed_done   = feed_done_r;
   assign feed_err    = feed_err_r;
   assign a_in0       = a_r[0];
   assign a_in1       = a_r[1];
   assign a_in2       = a_r[2];
   assign a_in3       = a_r[3];
   assign b_in0       = b_r[0];
   assign b_in1       = b_r[1];
   assign b_in2       = b_r[2];
   assign b_in3       = b_r[3];

endmodule

// File: tb/tb_sa_input_feeder.sv
// Randomized self-checking bench for sa_input_feeder; expected streams come
// from the matrix-level skew rule a_in_i = A[i][t-i], b_in_j = B[t-j][j].
module tb_sa_input_feeder;

   localparam int TIMEOUT = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        load_valid = 1'b0;
   logic        sa_done = 1'b0;
   logic [31:0] load_a = 32'd0;
   logic [31:0] load_b = 32'd0;
   logic        load_ready, sa_start, sa_in_valid, feed_done, feed_err;
   logic [7:0]  a_in0, a_in1, a_in2, a_in3, b_in0, b_in1, b_in2, b_in3;
   logic [7:0]  a_o [4];
   logic [7:0]  b_o [4];

   int          n_tests = 0;
   int          n_fail = 0;
   bit   [7:0]  ma [4][4];   // ma[i][k] = A[i][k]
   bit   [7:0]  mb [4][4];   // mb[k][j] = B[k][j]
   bit          err_exp = 1'b0;

   always #5 clk = ~clk;

   sa_input_feeder #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .load_valid(load_valid), .load_ready(load_ready),
      .load_a(load_a), .load_b(load_b),
      .sa_start(sa_start), .sa_in_valid(sa_in_valid),
      .a_in0(a_in0), .a_in1(a_in1), .a_in2(a_in2), .a_in3(a_in3),
      .b_in0(b_in0), .b_in1(b_in1), .b_in2(b_in2), .b_in3(b_in3),
      .sa_done(sa_done), .feed_done(feed_done), .feed_err(feed_err)
   );

   assign a_o[0] = a_in0;
   assign a_o[1] = a_in1;
   assign a_o[2] = a_in2;
   assign a_o[3] = a_in3;
   assign b_o[0] = b_in0;
   assign b_o[1] = b_in1;
   assign b_o[2] = b_in2;
   assign b_o[3] = b_in3;

   task automatic fill_random();
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 4; k++) begin
            ma[i][k] = 8'($urandom);
            mb[k][i] = 8'($urandom);
         end
   endtask

   task automatic fill_identity();
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 4; k++) begin
            ma[i][k] = 8'(16 * (k + 1) + i);
            mb[k][i] = 8'(128 + 4 * k + i);
         end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      load_valid = 1'b0;
      sa_done = 1'b0;
      #1;
      n_tests++;
      if ({sa_start, sa_in_valid, feed_done, feed_err, a_in0, a_in1, a_in2, a_in3,
           b_in0, b_in1, b_in2, b_in3} !== 68'd0)
         begin n_fail++; $display("FAIL reset_async got %b%b%b%b a=%h%h%h%h b=%h%h%h%h exp all 0",
            sa_start, sa_in_valid, feed_done, feed_err, a_in0, a_in1, a_in2, a_in3,
            b_in0, b_in1, b_in2, b_in3); end
      err_exp = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({load_ready, sa_start, sa_in_valid, feed_done, feed_err} !== 5'b10000)
         begin n_fail++; $display("FAIL reset_release got %b exp 10000",
            {load_ready, sa_start, sa_in_valid, feed_done, feed_err}); end
   endtask

   // mode 0: back-to-back beats, 1: valid pattern 1,0,1,0,1,1, 2: random gaps
   task automatic load_job(input int mode);
      bit [5:0] gap_pat;
      bit       v;
      int       k;
      int       g;
      gap_pat = 6'b110101;
      k = 0;
      g = 0;
      while (k < 4 && g < 64) begin
         n_tests++;
         if (load_ready !== 1'b1)
            begin n_fail++; $display("FAIL load_ready beat=%0d got %b exp 1", k, load_ready); end
         case (mode)
            0:       v = 1'b1;
            1:       v = (g < 6) ? gap_pat[g] : 1'b1;
            default: v = 1'($urandom_range(0, 1));
         endcase
         load_valid = v;
         for (int i = 0; i < 4; i++) begin
            load_a[8*i +: 8] = v ? ma[i][k] : 8'($urandom);
            load_b[8*i +: 8] = v ? mb[k][i] : 8'($urandom);
         end
         @(negedge clk);
         if (v) k++;
         g++;
      end
      load_valid = 1'b0;
      n_tests++;
      if (k != 4)
         begin n_fail++; $display("FAIL load_beats got %0d exp 4", k); end
      if (mode == 1) begin
         n_tests++;
         if (g != 6)
            begin n_fail++; $display("FAIL load_gap_cycles got %0d exp 6", g); end
      end
   endtask

   task automatic stream_job(input bit stray, input int abort_at);
      bit [7:0] ea;
      bit [7:0] eb;
      for (int t = 0; t < 10; t++) begin
         if (t == abort_at) return;
         n_tests++;
         if ({sa_start, sa_in_valid, load_ready, feed_done} !== 4'b1100)
            begin n_fail++; $display("FAIL stream_ctrl t=%0d got %b exp 1100", t,
               {sa_start, sa_in_valid, load_ready, feed_done}); end
         for (int i = 0; i < 4; i++) begin
            ea = (t >= i && t - i <= 3) ? ma[i][t-i] : 8'h00;
            eb = (t >= i && t - i <= 3) ? mb[t-i][i] : 8'h00;
            n_tests++;
            if (a_o[i] !== ea)
               begin n_fail++; $display("FAIL stream_a%0d t=%0d got %h exp %h", i, t, a_o[i], ea); end
            n_tests++;
            if (b_o[i] !== eb)
               begin n_fail++; $display("FAIL stream_b%0d t=%0d got %h exp %h", i, t, b_o[i], eb); end
         end
         if (stray) begin
            load_valid = 1'b1;
            load_a = $urandom;
            load_b = $urandom;
            sa_done = 1'b1;
         end
         @(negedge clk);
      end
      load_valid = 1'b0;
      sa_done = 1'b0;
   endtask

   // delay >= 0: raise sa_done in that WAIT_DONE cycle; delay < 0: never (timeout)
   task automatic finish_job(input int delay);
      int n;
      int exp_n;
      n = 0;
      exp_n = (delay < 0) ? TIMEOUT : delay + 1;
      while (feed_done !== 1'b1 && n < TIMEOUT + 20) begin
         n_tests++;
         if ({sa_start, sa_in_valid, load_ready} !== 3'b110 ||
             {a_in0, a_in1, a_in2, a_in3, b_in0, b_in1, b_in2, b_in3} !== 64'd0)
            begin n_fail++; $display("FAIL wait_outputs n=%0d got ctl=%b data=%h exp ctl=110 data=0", n,
               {sa_start, sa_in_valid, load_ready},
               {a_in0, a_in1, a_in2, a_in3, b_in0, b_in1, b_in2, b_in3}); end
         sa_done = (delay >= 0 && n == delay);
         @(negedge clk);
         n++;
      end
      sa_done = 1'b0;
      if (delay < 0) err_exp = 1'b1;
      n_tests++;
      if (n != exp_n)
         begin n_fail++; $display("FAIL wait_len got %0d exp %0d", n, exp_n); end
      n_tests++;
      if ({feed_done, sa_start, sa_in_valid, load_ready, feed_err} !== {4'b1000, err_exp})
         begin n_fail++; $display("FAIL finish_state got %b exp %b",
            {feed_done, sa_start, sa_in_valid, load_ready, feed_err}, {4'b1000, err_exp}); end
      @(negedge clk);
      n_tests++;
      if ({feed_done, load_ready, sa_start, sa_in_valid, feed_err} !== {4'b0100, err_exp})
         begin n_fail++; $display("FAIL after_finish got %b exp %b",
            {feed_done, load_ready, sa_start, sa_in_valid, feed_err}, {4'b0100, err_exp}); end
   endtask

   task automatic test_identity();
      fill_identity();
      load_job(0);
      stream_job(1'b0, -1);
      finish_job(3);
   endtask

   task automatic test_load_gaps();
      fill_random();
      load_job(1);
      stream_job(1'b0, -1);
      finish_job(0);
   endtask

   task automatic test_stray();
      fill_random();
      load_job(0);
      stream_job(1'b1, -1);
      finish_job(5);
   endtask

   task automatic test_timeout();
      fill_random();
      load_job(2);
      stream_job(1'b0, -1);
      finish_job(-1);
      fill_random();
      load_job(0);
      stream_job(1'b0, -1);
      finish_job(1);
   endtask

   task automatic test_reset_mid_stream();
      fill_random();
      load_job(0);
      stream_job(1'b0, 5);
      test_reset();
      fill_random();
      load_job(0);
      stream_job(1'b0, -1);
      finish_job(2);
   endtask

   task automatic test_random_jobs();
      for (int j = 0; j < 4; j++) begin
         fill_random();
         load_job(2);
         stream_job(1'($urandom_range(0, 1)), -1);
         finish_job(int'($urandom_range(0, 10)));
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_identity();
      test_load_gaps();
      test_stray();
      test_timeout();
      test_reset_mid_stream();
      test_random_jobs();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got no finish exp finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sa_input_feeder.md
SA_INPUT_FEEDER -- requirements
Module: sa_input_feeder

Interface
REQ-001 Parameter: TIMEOUT, default 32, meaning max cycles in WAIT_DONE before error.
REQ-002 Ports: clk  input  1  single clock, all logic on rising edge.
REQ-003 Ports: rst_n  input  1  asynchronous active-low reset.
REQ-004 Ports: load_valid  input  1  load beat offered.
REQ-005 Ports: load_ready  output  1  feeder accepts a beat this cycle.
REQ-006 Ports: load_a  input  32  beat k carries A column k: byte i = A[i][k], byte 0 = bits 7:0.
REQ-007 Ports: load_b  input  32  beat k carries B row k: byte j = B[k][j].
REQ-008 Ports: sa_start  output  1  array enable, level.
REQ-009 Ports: sa_in_valid  output  1  array data valid, level.
REQ-010 Ports: a_in0..a_in3  output  8 each  skewed row streams to array.
REQ-011 Ports: b_in0..b_in3  output  8 each  skewed column streams to array.
REQ-012 Ports: sa_done  input  1  completion flag from array.
REQ-013 Ports: feed_done  output  1  one-cycle pulse, job complete.
REQ-014 Ports: feed_err  output  1  sticky timeout flag.

Function
REQ-015 FSM states SHALL be LOAD, STREAM, WAIT_DONE, FINISH; reset state LOAD.
REQ-016 LOAD: load_ready=1; beat accepted when load_valid&load_ready; stored at buffer index beat_cnt (0..3); beat_cnt increments.
REQ-017 Accepting the 4th beat SHALL move the FSM to STREAM next cycle with t=0; load_ready=0 in every non-LOAD state; load_valid outside LOAD ignored, buffers unchanged.
REQ-018 STREAM lasts exactly 10 cycles, t=0..9 (4-bit counter); sa_start=1 and sa_in_valid=1 throughout.
REQ-019 In STREAM cycle t: a_in_i = A[i][t-i] if 0<=t-i<=3 else 0; b_in_j = B[t-j][j] if 0<=t-j<=3 else 0 (data non-zero only up to t=6; t=7..9 zero flush).
REQ-020 All array-facing outputs SHALL be registered: values for cycle t appear on outputs during the t-th STREAM cycle, no combinational path from inputs.
REQ-021 After t=9, FSM enters WAIT_DONE: sa_start=1, sa_in_valid=1, all a_in/b_in=0; wait counter starts at 0.
REQ-022 WAIT_DONE: sa_done=1 sampled -> FINISH next cycle; sa_done high during STREAM is ignored.
REQ-023 WAIT_DONE: wait counter reaching TIMEOUT without sa_done -> feed_err set (sticky until reset) and FSM goes to FINISH.
REQ-024 FINISH: feed_done=1 for exactly one cycle; sa_start=0, sa_in_valid=0; beat_cnt cleared; next state LOAD.
REQ-025 sa_start and sa_in_valid SHALL be 0 in LOAD and FINISH.
REQ-026 Data bytes are passed unmodified (8-bit, no sign interpretation, no arithmetic).
REQ-027 Back-to-back jobs: first beat of next job may be accepted in the cycle after FINISH; buffers overwritten beat by beat.

Reset
REQ-028 rst_n low SHALL immediately (asynchronously) force: state LOAD, beat_cnt=0, t=0, wait counter=0, load_ready=1 after release, sa_start=0, sa_in_valid=0, all a_in/b_in=0, feed_done=0, feed_err=0.
REQ-029 Reset asserted mid-LOAD or mid-STREAM SHALL discard partial job; buffer contents need not be cleared but are never emitted before 4 new beats.

Verification
REQ-030 Identity-skew: beats k=0..3 with load_a bytes = 0x10*(k+1)+i, load_b bytes = 0x80+4k+j -> a_in0 at t=0..3 = 0x10,0x20,0x30,0x40; a_in3 at t=3..6 = 0x13,0x23,0x33,0x43, zero elsewhere; b_in2 at t=2..5 = 0x82,0x86,0x8A,0x8E.
REQ-031 Load with gaps: load_valid toggling 1,0,1,0,1,1 -> exactly 4 beats captured, STREAM starts cycle after 4th accept, load_ready=0 from then.
REQ-032 Completion: sa_done asserted 3 cycles into WAIT_DONE -> feed_done single pulse 1 cycle later, feed_err=0, sa_in_valid=0 in FINISH, load_ready=1 next cycle.
REQ-033 Timeout: sa_done held 0 -> feed_err=1 after TIMEOUT=32 WAIT_DONE cycles, feed_done pulses, feed_err stays 1 across the next job until rst_n.
REQ-034 Reset mid-STREAM at t=5 -> all outputs 0 at once, after release load_ready=1, a fresh 4-beat job streams correctly from t=0.
REQ-035 Stray input: load_valid=1 held during STREAM with different data -> streamed bytes match original beats; sa_done=1 during STREAM ignored (full 10 cycles emitted).
